// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 4;

  typedef logic [1:0] byte_cnt_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte-to-word shift register; word_done flags the shift that completes a word.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        word_done
);

  byte_cnt_t   cnt;
  logic [23:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sh  <= '0;
    end else if (shift) begin
      cnt <= cnt + 2'd1;
      sh  <= {sh[15:0], data_byte};
    end
  end

  // The incoming byte is combined directly so the full word is usable on its last shift.
  assign word      = {sh, data_byte};
  assign word_done = shift && (cnt == byte_cnt_t'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and gates the core.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  state_t                state, state_nxt;
  logic                  xfer;
  logic                  asm_clr;
  logic                  asm_shift;
  logic                  word_done;
  logic [31:0]           asm_word;
  logic [31:0]           length;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [7:0]            acc;
  logic                  len_bad;
  logic                  last_word;

  assign in_ready  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign xfer      = in_valid && in_ready;
  assign asm_clr   = start || (state == ST_IDLE);
  // A start coincident with a transfer aborts, so that byte must not reach the assembler.
  assign asm_shift = xfer && !start && ((state == ST_LEN) || (state == ST_DATA));
  assign len_bad   = (asm_word == 32'd0) || (asm_word > 32'(MAX_WORDS));
  assign last_word = (32'(word_idx) + 32'd1) == length;

  prog_loader_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (asm_clr),
    .shift     (asm_shift),
    .data_byte (in_data),
    .word      (asm_word),
    .word_done (word_done)
  );

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_LEN;
    end else begin
      case (state)
        ST_LEN:  if (word_done) state_nxt = len_bad ? ST_ERR : ST_DATA;
        ST_DATA: if (word_done && last_word) state_nxt = ST_CSUM;
        ST_CSUM: if (xfer) state_nxt = (in_data == acc) ? ST_RUN : ST_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_en     <= 1'b0;
      error      <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      length     <= '0;
      word_idx   <= '0;
      word_count <= '0;
      acc        <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == ST_LEN) || (state_nxt == ST_DATA) || (state_nxt == ST_CSUM);
      done    <= (state_nxt == ST_RUN);
      cpu_en  <= (state_nxt == ST_RUN);
      error   <= (state_nxt == ST_ERR);
      mem_wen <= 1'b0;
      if (start) begin
        length     <= '0;
        word_idx   <= '0;
        word_count <= '0;
        acc        <= '0;
      end else begin
        if (asm_shift) acc <= acc ^ in_data;
        if ((state == ST_LEN) && word_done) length <= asm_word;
        if ((state == ST_DATA) && word_done) begin
          mem_wen    <= 1'b1;
          mem_addr   <= word_idx[ADDR_WIDTH-1:0];
          mem_wdata  <= asm_word;
          word_idx   <= word_idx + 1'b1;
          word_count <= word_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus time, popped by a write monitor.
module tb_prog_loader;
  localparam int AW   = 10;
  localparam int MAXW = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, mem_wen, cpu_en, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  prog_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_en(cpu_en), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int         total = 0;
  int         bad = 0;
  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] stream[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every memory strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {22'd0, mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(mon_e.addr));
        check("write_data", 64'(mem_wdata), 64'(mon_e.data));
      end
    end
  end

  // Reference: interpret the first n bytes of the stream. st: 0 unfinished, 1 RUN, 2 ERR.
  task automatic model(input int n, output int st, output int wc);
    logic [31:0] len;
    logic [7:0]  x;
    wr_t         t;
    st = 0;
    wc = 0;
    if (n < 4) return;
    len = {stream[0], stream[1], stream[2], stream[3]};
    if (len == 0 || len > MAXW) begin
      st = 2;
      return;
    end
    for (int w = 0; w < int'(len); w++) begin
      if (4 + 4 * w + 3 < n) begin
        t.addr = AW'(w);
        t.data = {stream[4+4*w], stream[5+4*w], stream[6+4*w], stream[7+4*w]};
        exp_q.push_back(t);
        wc++;
      end
    end
    if (n == 4 + 4 * int'(len) + 1) begin
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x ^= stream[i];
      st = (x == stream[n-1]) ? 1 : 2;
    end
  endtask

  task automatic push32(input logic [31:0] v);
    stream.push_back(v[31:24]);
    stream.push_back(v[23:16]);
    stream.push_back(v[15:8]);
    stream.push_back(v[7:0]);
  endtask

  task automatic build_random(input int nwords, input bit good);
    logic [7:0] x;
    stream.delete();
    push32(32'(nwords));
    for (int w = 0; w < nwords; w++) push32($urandom);
    x = 8'h00;
    foreach (stream[i]) x ^= stream[i];
    if (!good) x ^= 8'(1 + $urandom_range(0, 254));
    stream.push_back(x);
  endtask

  task automatic build_t1(input logic [7:0] csum);
    stream.delete();
    push32(32'd2);
    push32(32'h1122_3344);
    push32(32'hAABB_CCDD);
    stream.push_back(csum);
  endtask

  // Called just after a rising edge; returns just after a rising edge with in_valid low.
  task automatic send(input int n, input int gap_max);
    int waited;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_end(input int st, input int wc);
    @(negedge clk);
    check("done", 64'(done), 64'(st == 1));
    check("cpu_en", 64'(cpu_en), 64'(st == 1));
    check("error", 64'(error), 64'(st == 2));
    check("busy", 64'(busy), 64'd0);
    check("in_ready_end", 64'(in_ready), 64'd0);
    check("word_count", 64'(word_count), 64'(wc));
    check("writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_load(input bit do_start, input int gap_max);
    int st, wc;
    if (do_start) pulse_start();
    model(stream.size(), st, wc);
    send(stream.size(), gap_max);
    check_end(st, wc);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {5'd0, mem_wen, cpu_en, done, error, busy, in_ready, word_count, mem_addr, mem_wdata}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, wc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Good load, then reload from RUN
    build_t1(8'h46);
    run_load(1'b1, 0);
    pulse_start();
    @(negedge clk);
    check("reload_cpu_en", 64'(cpu_en), 64'd0);
    check("reload_done", 64'(done), 64'd0);
    check("reload_word_count", 64'(word_count), 64'd0);
    check("reload_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    stream.delete();
    push32(32'd1);
    push32(32'hDEAD_BEEF);
    stream.push_back(8'h23);
    run_load(1'b0, 0);

    // Bad checksum
    build_t1(8'h47);
    run_load(1'b1, 0);

    // Header length out of range
    stream.delete();
    push32(32'd0);
    run_load(1'b1, 0);
    stream.delete();
    push32(32'h0000_0401);
    run_load(1'b1, 0);

    // Sparse valid
    build_t1(8'h46);
    run_load(1'b1, 3);

    // Reset after six data bytes
    build_t1(8'h46);
    pulse_start();
    model(10, st, wc);
    send(10, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outs");
    @(negedge clk);
    check_all_zero("reset_hold_outs");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_writes_left", 64'(exp_q.size()), 64'd0);
    check_all_zero("post_reset_idle");
    run_load(1'b1, 1);

    // Randomised loads
    for (int k = 0; k < 8; k++) begin
      build_random($urandom_range(1, 6), ($urandom_range(0, 2) != 0));
      run_load(1'b1, $urandom_range(0, 2));
    end

    // Largest legal program
    build_random(MAXW, 1'b1);
    run_load(1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
